aes256_round_key_scheduler: RTL and testbench
=============================================

# aes256_round_key_scheduler

Sequencing controller that owns the AES-256 key expansion engine. It accepts a 256-bit cipher key from a requester and drives the engine through one full expansion. It captures the 15 round keys into an internal key store, then serves indexed round-key reads to the cipher round datapath in either encrypt order or decrypt order. It sits between the key-load path and the AES round core, so the round core never talks to the expansion engine directly.

## Interface
- NR, 14: number of rounds; the key store holds NR+1 round keys.
- TIMEOUT, 64: maximum number of consecutive EXPAND cycles without exp_rdy before an abort.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- key_req  in  1  requester has a valid key_in; held high until key_ack.
- key_in  in  256  cipher key; sampled on acceptance.
- key_ack  out  1  one-cycle pulse; key accepted.
- exp_start  out  1  engine run request; high for the whole EXPAND state.
- exp_key  out  256  registered copy of the accepted key; stable while exp_start is high.
- exp_subkey  in  128  round key currently presented by the engine.
- exp_rdy  in  1  exp_subkey is valid this cycle; one key per high cycle.
- rk_rd_en  in  1  round-key read request.
- rk_rd_idx  in  4  round index, 0..NR.
- decrypt  in  1  1 = reverse order: the physical index read is NR - rk_rd_idx.
- rk_data  out  128  registered read data.
- rk_valid  out  1  rk_data is valid for the previous cycle's read.
- keys_ready  out  1  key store holds a complete schedule.
- busy  out  1  high in LOAD or EXPAND.
- err  out  1  one-cycle pulse on an illegal read or an expansion timeout.

## Operation
- States:
  - IDLE: reset state.
  - LOAD: one cycle; key register written.
  - EXPAND: capturing keys.
  - READY: schedule complete.
- Transitions:
  - IDLE or READY with key_req=1 -> LOAD. In the same edge the key register is set to key_in, the capture count is set to 0, and keys_ready is cleared.
  - LOAD -> EXPAND unconditionally.
  - EXPAND, on a cycle with exp_rdy=1: exp_subkey is written to store[count] and count increments. When the capture is the (NR+1)th, the next state is READY.
  - EXPAND, on a cycle with exp_rdy=0: the idle counter increments. exp_rdy=1 resets the idle counter. When the idle counter reaches TIMEOUT, the block pulses err, returns to IDLE, and keys_ready stays 0.
- key_req is ignored in LOAD and EXPAND: no ack, no state change, and the requester keeps holding it. A request arriving during EXPAND is accepted once READY is reached.
- Once count = NR+1, further exp_rdy pulses are ignored.
- Outputs:
  - exp_start = (state == EXPAND).
  - busy = LOAD or EXPAND.
  - keys_ready = (state == READY).
- Reads, sampled when rk_rd_en=1:
  - Legal read: state READY and rk_rd_idx ≤ NR. rk_data is loaded from the mapped store entry and rk_valid=1 on the next cycle.
  - Illegal read: any other state, or rk_rd_idx > NR. err pulses on the next cycle, rk_valid=0, and rk_data holds its previous value.
- rk_rd_en=0: rk_valid=0 on the next cycle; rk_data holds.
- Simultaneous events in READY:
  - A legal read completes normally from the old store in the same cycle that key_req is accepted.
  - Reads issued during the following LOAD or EXPAND are illegal.
- Reset values:
  - State IDLE.
  - key_ack, exp_start, rk_valid, keys_ready, busy, and err are all 0.
  - rk_data, exp_key, and all store entries are 0.
- Reset during EXPAND aborts immediately. exp_start drops asynchronously, and the store is cleared.

## Timing
- Cycle 0: key_req=1 in IDLE.
- Cycle 1: state LOAD, key_ack=1, busy=1, exp_key=key_in.
- Cycle 2: exp_start=1.
- With exp_rdy high for cycles 2..16, the store is full at the end of cycle 16. Cycle 17 has keys_ready=1, exp_start=0, busy=0.
- Stalls in exp_rdy extend EXPAND one cycle per stall cycle.
- Read latency is 1 cycle: a request in cycle n gives rk_data/rk_valid in cycle n+1. A new read may be issued every cycle.
- err and key_ack are single-cycle pulses and are registered.

## Test plan
- Reset, then key_req with key_in = 000102…1f (256-bit) and an engine model driving exp_rdy for cycles 2..16 -> key_ack in cycle 1, keys_ready in cycle 17. Reading idx 0 returns 000102…0f, idx 1 returns 101112…1f, and idx 14 returns FIPS-197 round key 14 (24fc79ccbf0979e9371ac23c6d68de36).
- decrypt=1 with idx 0 -> same data as decrypt=0 with idx 14. Back-to-back reads of idx 0..14 -> rk_valid high for 15 consecutive cycles.
- exp_rdy deasserted for 10 cycles mid-expansion -> keys_ready delayed exactly 10 cycles and the stored keys are unchanged. exp_rdy low for 64 cycles -> err pulse, state IDLE, keys_ready=0.
- Read with idx 15, or any read while busy=1 -> err pulse one cycle later, rk_valid=0, rk_data unchanged.
- key_req held during EXPAND -> no key_ack until the cycle after keys_ready rises; then LOAD and keys_ready drops.
- Assert reset in cycle 8 of EXPAND -> exp_start, busy, and keys_ready are 0 immediately. A read of idx 0 after reset returns err.

Source files
------------

// File: rtl/aes256_round_key_scheduler_if.sv
// aes256_round_key_scheduler_if
// Bundles every non-clock, non-reset signal of the AES-256 round-key scheduler.
//   key_req/key_in/key_ack         : key-load handshake with the requester
//   exp_start/exp_key              : run request and key towards the expansion engine
//   exp_subkey/exp_rdy             : round keys streamed back by the engine
//   rk_rd_en/rk_rd_idx/decrypt     : indexed round-key read from the round core
//   rk_data/rk_valid               : registered read response
//   keys_ready/busy/err            : status
// The slave modport is the scheduler's view; master is the surrounding system.
interface aes256_round_key_scheduler_if;
    logic         key_req;
    logic [255:0] key_in;
    logic         key_ack;
    logic         exp_start;
    logic [255:0] exp_key;
    logic [127:0] exp_subkey;
    logic         exp_rdy;
    logic         rk_rd_en;
    logic [3:0]   rk_rd_idx;
    logic         decrypt;
    logic [127:0] rk_data;
    logic         rk_valid;
    logic         keys_ready;
    logic         busy;
    logic         err;

    modport slave (
        input  key_req, key_in, exp_subkey, exp_rdy, rk_rd_en, rk_rd_idx, decrypt,
        output key_ack, exp_start, exp_key, rk_data, rk_valid, keys_ready, busy, err
    );

    modport master (
        output key_req, key_in, exp_subkey, exp_rdy, rk_rd_en, rk_rd_idx, decrypt,
        input  key_ack, exp_start, exp_key, rk_data, rk_valid, keys_ready, busy, err
    );
endinterface

// File: rtl/aes256_round_key_scheduler.sv
// aes256_round_key_scheduler
// Accepts a 256-bit cipher key, drives the key expansion engine through one
// full run, captures the NR+1 round keys into a local store and serves
// one-cycle-latency indexed reads in encrypt or decrypt order.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset, clears all state
//   bus   : aes256_round_key_scheduler_if.slave (key load, engine, reads, status)
module aes256_round_key_scheduler #(
    parameter int NR      = 14,
    parameter int TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    aes256_round_key_scheduler_if.slave   bus
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXPAND,
        READY
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [3:0]          count;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [127:0]        store [0:NR];

    logic                accept;
    logic                capture;
    logic                timeout;
    logic                rd_legal;
    logic [3:0]          phys_idx;

    logic                key_ack_q;
    logic [255:0]        exp_key_q;
    logic [127:0]        rk_data_q;
    logic                rk_valid_q;
    logic                err_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A new key is only taken in IDLE or READY; while the
    // engine runs, key_req is simply left pending. Capturing stops as soon as
    // the NR+1th key lands, so stray exp_rdy pulses never overrun the store.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        timeout = 1'b0;
        case (state_q)
            IDLE, READY: begin
                if (bus.key_req) begin
                    accept  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = EXPAND;
            end
            EXPAND: begin
                if (bus.exp_rdy) begin
                    if (count <= 4'(NR)) begin
                        capture = 1'b1;
                        if (count == 4'(NR)) begin
                            state_d = READY;
                        end
                    end
                end else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Decrypt order walks the schedule backwards, so the physical entry is
    // mirrored around NR. Only legal indices ever reach the store.
    always_comb begin
        rd_legal = bus.rk_rd_en && (state_q == READY) && (bus.rk_rd_idx <= 4'(NR));
        phys_idx = bus.decrypt ? (4'(NR) - bus.rk_rd_idx) : bus.rk_rd_idx;
    end

    // Key register, capture bookkeeping, key store and read port. A read in
    // READY that coincides with a key acceptance still sees the old store,
    // because the store is only rewritten once EXPAND begins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_ack_q  <= 1'b0;
            exp_key_q  <= '0;
            count      <= '0;
            idle_cnt   <= '0;
            rk_data_q  <= '0;
            rk_valid_q <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i <= NR; i++) begin
                store[i] <= '0;
            end
        end else begin
            key_ack_q <= accept;
            if (accept) begin
                exp_key_q <= bus.key_in;
                count     <= '0;
                idle_cnt  <= '0;
            end
            if (state_q == EXPAND) begin
                if (bus.exp_rdy) begin
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
            if (capture) begin
                store[count] <= bus.exp_subkey;
                count        <= count + 4'd1;
            end
            rk_valid_q <= rd_legal;
            if (rd_legal) begin
                rk_data_q <= store[phys_idx];
            end
            err_q <= (bus.rk_rd_en && !rd_legal) || timeout;
        end
    end

    assign bus.key_ack    = key_ack_q;
    assign bus.exp_key    = exp_key_q;
    assign bus.rk_data    = rk_data_q;
    assign bus.rk_valid   = rk_valid_q;
    assign bus.err        = err_q;
    assign bus.exp_start  = (state_q == EXPAND);
    assign bus.busy       = (state_q == LOAD) || (state_q == EXPAND);
    assign bus.keys_ready = (state_q == READY);

endmodule

// File: tb/tb_aes256_round_key_scheduler.sv
// tb_aes256_round_key_scheduler
// Directed bench for aes256_round_key_scheduler. A canned engine model
// streams the FIPS-197 AES-256 schedule for key 000102..1f; each read issued
// pushes its expected response into a scoreboard queue, and a monitor on the
// falling edge pops and compares whenever the DUT shows rk_valid or err.
module tb_aes256_round_key_scheduler;

    localparam logic [255:0] KEY1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY2 = 256'hfedcba9876543210_0123456789abcdef_5a5a5a5a5a5a5a5a_a5a5a5a5a5a5a5a5;
    localparam logic [127:0] JUNK = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

    typedef struct {
        logic         err;
        logic [127:0] data;
    } exp_t;

    logic clk;
    logic reset;
    aes256_round_key_scheduler_if bus ();

    aes256_round_key_scheduler #(.NR(14), .TIMEOUT(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [127:0] rk_tab [0:14] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'h101112131415161718191a1b1c1d1e1f,
        128'ha573c29fa176c498a97fce93a572c09c,
        128'h1651a8cd0244beda1a5da4c10640bade,
        128'hae87dff00ff11b68a68ed5fb03fc1567,
        128'h6de1f1486fa54f9275f8eb5373b8518d,
        128'hc656827fc9a799176f294cec6cd5598b,
        128'h3de23a75524775e727bf9eb45407cf39,
        128'h0bdc905fc27b0948ad5245a4c1871c2f,
        128'h45f5a66017b2d387300d4d33640a820a,
        128'h7ccff71cbeb4fe5413e6bbf0d261a7df,
        128'hf01afafee7a82979d7a5644ab3afe640,
        128'h2541fe719bf500258813bbd55a721c0a,
        128'h4e5a6699a9f24fe07e572baacdf8cdea,
        128'h24fc79ccbf0979e9371ac23c6d68de36
    };

    exp_t         sb_q [$];
    int           compared = 0;
    int           mismatched = 0;
    int           cyc = 0;
    int           run_len = 0;
    int           max_run = 0;
    int           t0;
    logic         model_ready = 1'b0;
    logic [127:0] model_last_data = '0;
    logic         ack_seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Compares a single observed value against the bench's expectation.
    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs; a read also queues its expected response.
    task automatic applyStimulus(input logic rd_en, input logic [3:0] idx, input logic dec,
                                 input logic rdy, input logic [127:0] sub, input logic req);
        exp_t e;
        bus.rk_rd_en   = rd_en;
        bus.rk_rd_idx  = idx;
        bus.decrypt    = dec;
        bus.exp_rdy    = rdy;
        bus.exp_subkey = sub;
        bus.key_req    = req;
        if (rd_en) begin
            if (model_ready && idx <= 4'd14) begin
                model_last_data = rk_tab[dec ? (4'd14 - idx) : idx];
                e.err = 1'b0;
            end else begin
                e.err = 1'b1;
            end
            e.data = model_last_data;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            if (bus.rk_valid) begin
                run_len = run_len + 1;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (bus.rk_valid || bus.err) begin
                compared++;
                if (sb_q.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL unexpected_output: got valid=%0b err=%0b data=%h, expected no response",
                             bus.rk_valid, bus.err, bus.rk_data);
                end else begin
                    e = sb_q.pop_front();
                    if ({bus.rk_valid, bus.err, bus.rk_data} !== {~e.err, e.err, e.data}) begin
                        mismatched++;
                        $display("[TB] FAIL read_response: got valid=%0b err=%0b data=%h, expected valid=%0b err=%0b data=%h",
                                 bus.rk_valid, bus.err, bus.rk_data, ~e.err, e.err, e.data);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        reset          = 1'b1;
        bus.key_req    = 1'b0;
        bus.key_in     = '0;
        bus.exp_subkey = '0;
        bus.exp_rdy    = 1'b0;
        bus.rk_rd_en   = 1'b0;
        bus.rk_rd_idx  = '0;
        bus.decrypt    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_key_ack",    256'(bus.key_ack),    256'(0));
        checkOutput("rst_exp_start",  256'(bus.exp_start),  256'(0));
        checkOutput("rst_rk_valid",   256'(bus.rk_valid),   256'(0));
        checkOutput("rst_keys_ready", 256'(bus.keys_ready), 256'(0));
        checkOutput("rst_busy",       256'(bus.busy),       256'(0));
        checkOutput("rst_err",        256'(bus.err),        256'(0));
        checkOutput("rst_rk_data",    256'(bus.rk_data),    256'(0));
        checkOutput("rst_exp_key",    bus.exp_key,          256'(0));
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, '0, 0);

        $display("[TB] read before any key is loaded");
        applyStimulus(1, 0, 0, 0, '0, 0);
        applyStimulus(0, 0, 0, 0, '0, 0);

        $display("[TB] nominal expansion");
        bus.key_in = KEY1;
        t0 = cyc;
        applyStimulus(0, 0, 0, 0, '0, 1);
        checkOutput("c1_key_ack", 256'(bus.key_ack), 256'(1));
        checkOutput("c1_busy",    256'(bus.busy),    256'(1));
        checkOutput("c1_exp_key", bus.exp_key,       KEY1);
        applyStimulus(0, 0, 0, 0, '0, 0);
        checkOutput("c2_exp_start", 256'(bus.exp_start), 256'(1));
        checkOutput("c2_key_ack",   256'(bus.key_ack),   256'(0));
        for (int i = 0; i < 15; i++) applyStimulus(0, 0, 0, 1, rk_tab[i], 0);
        checkOutput("c17_keys_ready", 256'(bus.keys_ready), 256'(1));
        checkOutput("c17_exp_start",  256'(bus.exp_start),  256'(0));
        checkOutput("c17_busy",       256'(bus.busy),       256'(0));
        checkOutput("c17_latency",    256'(cyc - t0),       256'(17));
        model_ready = 1'b1;
        applyStimulus(1, 0,  0, 0, '0, 0);
        applyStimulus(1, 1,  0, 0, '0, 0);
        applyStimulus(1, 14, 0, 0, '0, 0);
        applyStimulus(1, 15, 0, 0, '0, 0);
        applyStimulus(1, 0,  1, 0, '0, 0);
        applyStimulus(1, 14, 1, 0, '0, 0);
        applyStimulus(0, 0,  0, 0, '0, 0);
        applyStimulus(0, 0,  0, 0, '0, 0);

        $display("[TB] reload from READY with a concurrent read, stalled engine");
        bus.key_in = KEY2;
        t0 = cyc;
        applyStimulus(1, 5, 0, 0, '0, 1);
        model_ready = 1'b0;
        checkOutput("s1_key_ack",    256'(bus.key_ack),    256'(1));
        checkOutput("s1_keys_ready", 256'(bus.keys_ready), 256'(0));
        checkOutput("s1_exp_key",    bus.exp_key,          KEY2);
        applyStimulus(1, 3, 0, 0, '0, 0);
        for (int i = 0; i < 15; i++) begin
            if (i == 7) begin
                repeat (10) applyStimulus(0, 0, 0, 0, JUNK, 0);
            end
            applyStimulus(0, 0, 0, 1, rk_tab[i], 0);
        end
        checkOutput("s_keys_ready", 256'(bus.keys_ready), 256'(1));
        checkOutput("s_latency",    256'(cyc - t0),       256'(27));
        model_ready = 1'b1;
        max_run = 0;
        for (int i = 0; i < 15; i++) applyStimulus(1, 4'(i), 0, 0, '0, 0);
        applyStimulus(0, 0, 0, 0, '0, 0);
        applyStimulus(0, 0, 0, 0, '0, 0);
        checkOutput("b2b_valid_run", 256'(max_run), 256'(15));

        $display("[TB] key_req held during EXPAND");
        bus.key_in = KEY1;
        t0 = cyc;
        applyStimulus(0, 0, 0, 0, '0, 1);
        model_ready = 1'b0;
        checkOutput("h1_key_ack", 256'(bus.key_ack), 256'(1));
        applyStimulus(0, 0, 0, 0, '0, 0);
        ack_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(0, 0, 0, 1, rk_tab[i], (i >= 3));
            if (bus.key_ack) ack_seen = 1'b1;
        end
        checkOutput("h_no_ack_in_expand", 256'(ack_seen),       256'(0));
        checkOutput("h17_keys_ready",     256'(bus.keys_ready), 256'(1));
        bus.key_in = KEY2;
        applyStimulus(0, 0, 0, 0, '0, 1);
        checkOutput("h18_key_ack",    256'(bus.key_ack),    256'(1));
        checkOutput("h18_keys_ready", 256'(bus.keys_ready), 256'(0));
        checkOutput("h18_busy",       256'(bus.busy),       256'(1));
        checkOutput("h18_latency",    256'(cyc - t0),       256'(18));

        $display("[TB] reset in the middle of EXPAND");
        applyStimulus(0, 0, 0, 0, '0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1, rk_tab[i], 0);
        checkOutput("r_exp_start_before", 256'(bus.exp_start), 256'(1));
        #2 reset = 1'b1;
        #1;
        checkOutput("r_exp_start",  256'(bus.exp_start),  256'(0));
        checkOutput("r_busy",       256'(bus.busy),       256'(0));
        checkOutput("r_keys_ready", 256'(bus.keys_ready), 256'(0));
        checkOutput("r_rk_data",    256'(bus.rk_data),    256'(0));
        model_last_data = '0;
        @(posedge clk);
        #1 reset = 1'b0;
        applyStimulus(0, 0, 0, 0, '0, 0);
        applyStimulus(1, 0, 0, 0, '0, 0);
        applyStimulus(0, 0, 0, 0, '0, 0);

        $display("[TB] engine never answers");
        bus.key_in = KEY2;
        applyStimulus(0, 0, 0, 0, '0, 1);
        applyStimulus(0, 0, 0, 0, '0, 0);
        for (int i = 0; i < 63; i++) applyStimulus(0, 0, 0, 0, JUNK, 0);
        checkOutput("t65_busy", 256'(bus.busy), 256'(1));
        checkOutput("t65_err",  256'(bus.err),  256'(0));
        e.err  = 1'b1;
        e.data = model_last_data;
        sb_q.push_back(e);
        applyStimulus(0, 0, 0, 0, JUNK, 0);
        checkOutput("t66_busy",       256'(bus.busy),       256'(0));
        checkOutput("t66_keys_ready", 256'(bus.keys_ready), 256'(0));
        checkOutput("t66_exp_start",  256'(bus.exp_start),  256'(0));
        applyStimulus(0, 0, 0, 0, '0, 0);
        applyStimulus(0, 0, 0, 0, '0, 0);
        checkOutput("scoreboard_drained", 256'(sb_q.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
